// File: rtl/rotemp_host_reader_if.sv
// Host-side bundle for the ring-oscillator temperature sensor reader: command request,
// the two serial lines and the result/status strobes.
interface rotemp_host_reader_if #(
    parameter int NBYTES = 3
) ();
    logic                start;
    logic [7:0]          cmd;
    logic                ser_rx;
    logic                ser_tx;
    logic                busy;
    logic [8*NBYTES-1:0] result;
    logic                result_valid;
    logic                frame_err;
    logic                timeout_err;

    modport master (
        input  start, cmd, ser_rx,
        output ser_tx, busy, result, result_valid, frame_err, timeout_err
    );

    modport slave (
        output start, cmd, ser_rx,
        input  ser_tx, busy, result, result_valid, frame_err, timeout_err
    );
endinterface

// File: rtl/rotemp_host_reader.sv
// Serial master for the temperature sensor: sends one 8N1 command byte, then collects an
// NBYTES little-endian response into a word, reporting success, framing error or timeout.
module rotemp_host_reader #(
    parameter int CLK_FREQ    = 10000,
    parameter int BAUD        = 1000,
    parameter int NBYTES      = 3,
    parameter int TIMEOUT_CYC = 2000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rotemp_host_reader_if.master   bus
);
    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int CNT_W = $clog2(DIV);
    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    localparam int IDX_W = $clog2(NBYTES + 1);
    localparam int RW    = 8 * NBYTES;

    typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_DONE} state_e;

    state_e             state_q, state_d;
    logic               tx_q, tx_d;
    logic [8:0]         tx_shift_q, tx_shift_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   div_cnt_q, div_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         rx_sync_q, rx_sync_d;
    logic               rx_prev_q, rx_prev_d;
    logic [7:0]         rx_shift_q, rx_shift_d;
    logic [RW-1:0]      shadow_q, shadow_d;
    logic [RW-1:0]      result_q, result_d;
    logic               busy_q, busy_d;
    logic               result_valid_q, result_valid_d;
    logic               frame_err_q, frame_err_d;
    logic               timeout_err_q, timeout_err_d;

    logic               rx_s;
    logic               rx_fall;
    logic [CNT_W-1:0]   sample_at;

    assign rx_s    = rx_sync_q[1];
    assign rx_fall = rx_prev_q & ~rx_s;

    // NOTE: every register, including the shadow word, has a reset value so a reset
    // mid-transaction leaves no stale partial result and the line idles high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            tx_q           <= 1'b1;
            tx_shift_q     <= '0;
            bit_cnt_q      <= '0;
            div_cnt_q      <= '0;
            tmo_cnt_q      <= '0;
            idx_q          <= '0;
            rx_sync_q      <= 2'b11;
            rx_prev_q      <= 1'b1;
            rx_shift_q     <= '0;
            shadow_q       <= '0;
            result_q       <= '0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            // NOTE: state updates use non-blocking assignments so all flops sample together.
            state_q        <= state_d;
            tx_q           <= tx_d;
            tx_shift_q     <= tx_shift_d;
            bit_cnt_q      <= bit_cnt_d;
            div_cnt_q      <= div_cnt_d;
            tmo_cnt_q      <= tmo_cnt_d;
            idx_q          <= idx_d;
            rx_sync_q      <= rx_sync_d;
            rx_prev_q      <= rx_prev_d;
            rx_shift_q     <= rx_shift_d;
            shadow_q       <= shadow_d;
            result_q       <= result_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
            frame_err_q    <= frame_err_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
        state_d        = state_q;
        tx_d           = tx_q;
        tx_shift_d     = tx_shift_q;
        bit_cnt_d      = bit_cnt_q;
        div_cnt_d      = div_cnt_q;
        tmo_cnt_d      = tmo_cnt_q;
        idx_d          = idx_q;
        rx_sync_d      = {rx_sync_q[0], bus.ser_rx};
        rx_prev_d      = rx_s;
        rx_shift_d     = rx_shift_q;
        shadow_d       = shadow_q;
        result_d       = result_q;
        busy_d         = busy_q;
        result_valid_d = 1'b0;
        frame_err_d    = 1'b0;
        timeout_err_d  = 1'b0;
        // First sample lands mid start bit, later ones a full bit apart.
        sample_at      = (bit_cnt_q == 4'd0) ? CNT_W'(DIV / 2 - 1) : CNT_W'(DIV - 1);

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d    = S_SEND;
                    tx_d       = 1'b0;
                    tx_shift_d = {1'b1, bus.cmd};
                    bit_cnt_d  = '0;
                    div_cnt_d  = '0;
                    shadow_d   = '0;
                    busy_d     = 1'b1;
                end
            end
            S_SEND: begin
                if (div_cnt_q == CNT_W'(DIV - 1)) begin
                    div_cnt_d = '0;
                    if (bit_cnt_q == 4'd9) begin
                        tx_d      = 1'b1;
                        state_d   = S_WAIT;
                        idx_d     = '0;
                        tmo_cnt_d = '0;
                    end else begin
                        tx_d       = tx_shift_q[0];
                        tx_shift_d = {1'b1, tx_shift_q[8:1]};
                        bit_cnt_d  = bit_cnt_q + 4'd1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (rx_fall) begin
                    state_d   = S_RECV;
                    tmo_cnt_d = '0;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    timeout_err_d = 1'b1;
                    busy_d        = 1'b0;
                    state_d       = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            S_RECV: begin
                if (div_cnt_q == sample_at) begin
                    div_cnt_d = '0;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd0) begin
                        if (rx_s) begin
                            frame_err_d = 1'b1;
                            state_d     = S_WAIT;
                        end
                    end else if (bit_cnt_q == 4'd9) begin
                        if (rx_s) begin
                            shadow_d[8*idx_q +: 8] = rx_shift_q;
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = (idx_q == IDX_W'(NBYTES - 1)) ? S_DONE : S_WAIT;
                        end else begin
                            frame_err_d = 1'b1;
                            busy_d      = 1'b0;
                            state_d     = S_IDLE;
                        end
                    end else begin
                        rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    end
                end else begin
                    div_cnt_d = div_cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                result_d       = shadow_q;
                result_valid_d = 1'b1;
                busy_d         = 1'b0;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.ser_tx       = tx_q;
    assign bus.busy         = busy_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.frame_err    = frame_err_q;
    assign bus.timeout_err  = timeout_err_q;
endmodule

// File: tb/tb_rotemp_host_reader.sv
// Bench for rotemp_host_reader: plays the sensor side of the serial link and scores the
// result/error strobes against an expectation queue filled when each request is issued.
module tb_rotemp_host_reader;
    localparam int CLK_FREQ    = 10000;
    localparam int BAUD        = 1000;
    localparam int NBYTES      = 3;
    localparam int TIMEOUT_CYC = 2000;
    localparam int DIV         = CLK_FREQ / BAUD;
    // Response start edge to result_valid: 2 sync flops, half a bit, 9 bits, then DONE.
    localparam int VALID_LAT   = 2 + DIV / 2 + 9 * DIV + 2;

    typedef enum int {EV_NONE, EV_VALID, EV_FERR, EV_TMO} ev_e;
    typedef struct {
        ev_e         kind;
        logic [23:0] value;
    } exp_t;
    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] data;
        int          bad_byte;
        bit          glitch;
        bit          no_resp;
        ev_e         exp_kind;
        logic [23:0] exp_result;
    } vec_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_pass;
    int   n_checks;

    exp_t        exp_q[$];
    logic [23:0] model_result;
    int          last_valid_cyc;
    int          last_tmo_cyc;
    int          last_busy_fall_cyc;
    int          n_valid;
    logic        busy_prev;
    int          npulse;
    ev_e         seen;
    exp_t        e;
    vec_t        vecs[8];

    rotemp_host_reader_if #(.NBYTES(NBYTES)) bus ();

    rotemp_host_reader #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .NBYTES(NBYTES), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard side: every strobe the DUT raises must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            npulse = int'(bus.result_valid) + int'(bus.frame_err) + int'(bus.timeout_err);
            if (npulse > 0) begin
                check("pulse_exclusive", npulse, 1);
                if (bus.result_valid) begin
                    seen = EV_VALID; last_valid_cyc = cyc; n_valid++;
                end else if (bus.frame_err) begin
                    seen = EV_FERR;
                end else begin
                    seen = EV_TMO; last_tmo_cyc = cyc;
                end
                if (exp_q.size() == 0) begin
                    check("unexpected_event", seen, EV_NONE);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", seen, e.kind);
                    check("event_result", bus.result, e.value);
                end
            end
            if (busy_prev && !bus.busy) last_busy_fall_cyc = cyc;
            busy_prev = bus.busy;
        end
    end

    task automatic send_cmd(input logic [7:0] c, output int acc_cyc);
        logic [9:0] frame;
        int bad;
        frame = {1'b1, c, 1'b0};
        @(negedge clk);
        check("tx_idle_before", bus.ser_tx, 1);
        bus.cmd   = c;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        acc_cyc   = cyc;
        check("busy_set", bus.busy, 1);
        for (int k = 0; k < 10; k++) begin
            bad = 0;
            for (int j = 0; j < DIV; j++) begin
                if (k != 0 || j != 0) @(negedge clk);
                if (bus.ser_tx !== frame[k]) bad++;
            end
            check($sformatf("tx_bit%0d_bad_samples", k), bad, 0);
        end
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            bus.ser_rx = f[k];
            repeat (DIV) @(negedge clk);
        end
        bus.ser_rx = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (bus.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", bus.busy, 0);
        repeat (2) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic run_vec(input vec_t v);
        int acc;
        if (v.glitch) exp_q.push_back('{EV_FERR, model_result});
        exp_q.push_back('{v.exp_kind, v.exp_result});
        model_result = v.exp_result;
        send_cmd(v.cmd, acc);
        if (!v.no_resp) begin
            if (v.glitch) begin
                bus.ser_rx = 1'b0;
                repeat (3) @(negedge clk);
                bus.ser_rx = 1'b1;
                repeat (20) @(negedge clk);
            end
            for (int i = 0; i < NBYTES; i++) begin
                if (v.bad_byte < 0 || i <= v.bad_byte) begin
                    send_byte(v.data[8*i +: 8], (i != v.bad_byte));
                    repeat (2) @(negedge clk);
                end
            end
        end
        wait_idle(TIMEOUT_CYC + 300);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int acc;
        int fall_cyc;
        int lows;
        int v0;

        n_pass = 0; n_checks = 0; n_valid = 0; busy_prev = 1'b0;
        last_valid_cyc = 0; last_tmo_cyc = 0; last_busy_fall_cyc = 0;
        model_result = 24'h0;

        vecs[0] = '{8'h5A, 24'h0055AA, 1,  1'b0, 1'b0, EV_FERR,  24'h0F1234};
        vecs[1] = '{8'h01, 24'h030201, -1, 1'b0, 1'b0, EV_VALID, 24'h030201};
        vecs[2] = '{8'hC3, 24'hABCDEF, -1, 1'b1, 1'b0, EV_VALID, 24'hABCDEF};
        vecs[3] = '{8'h00, 24'hFFFFFF, -1, 1'b0, 1'b0, EV_VALID, 24'hFFFFFF};
        vecs[4] = '{8'hFF, 24'h123456, 2,  1'b0, 1'b0, EV_FERR,  24'hFFFFFF};
        vecs[5] = '{8'h7E, 24'h000000, 0,  1'b0, 1'b0, EV_FERR,  24'hFFFFFF};
        vecs[6] = '{8'h80, 24'h000000, -1, 1'b0, 1'b0, EV_VALID, 24'h000000};
        vecs[7] = '{8'h96, 24'h000000, -1, 1'b0, 1'b1, EV_TMO,   24'h000000};

        rst_n = 1'b0; bus.start = 1'b0; bus.cmd = 8'h00; bus.ser_rx = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ser_tx", bus.ser_tx, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_result", bus.result, 0);
        check("rst_result_valid", bus.result_valid, 0);
        check("rst_frame_err", bus.frame_err, 0);
        check("rst_timeout_err", bus.timeout_err, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Command 0xA5, then a clean 3-byte response with exact result_valid latency.
        exp_q.push_back('{EV_VALID, 24'h0F1234});
        model_result = 24'h0F1234;
        send_cmd(8'hA5, acc);
        send_byte(8'h34, 1'b1); repeat (2) @(negedge clk);
        send_byte(8'h12, 1'b1); repeat (2) @(negedge clk);
        v0 = n_valid;
        fall_cyc = cyc;
        send_byte(8'h0F, 1'b1);
        repeat (5) @(negedge clk);
        check("valid_latency", last_valid_cyc - fall_cyc, VALID_LAT);
        check("busy_falls_with_valid", last_busy_fall_cyc, last_valid_cyc);
        check("single_valid_pulse", n_valid - v0, 1);
        check("result_0f1234", bus.result, 24'h0F1234);
        wait_idle(50);

        // No response: timeout exactly TIMEOUT_CYC cycles after the command ends.
        exp_q.push_back('{EV_TMO, 24'h0F1234});
        send_cmd(8'h5C, acc);
        wait_idle(TIMEOUT_CYC + 300);
        check("timeout_latency", last_tmo_cyc - acc, 10 * DIV + TIMEOUT_CYC);
        check("result_kept_after_timeout", bus.result, 24'h0F1234);
        repeat (5) @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset in the middle of data bit 3 of a command frame.
        @(negedge clk);
        bus.cmd = 8'hE7; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (44) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ser_tx", bus.ser_tx, 1);
        check("async_rst_busy", bus.busy, 0);
        check("async_rst_result", bus.result, 0);
        model_result = 24'h0;
        @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.ser_tx) lows++;
        end
        check("abandoned_frame_quiet", lows, 0);

        // Fresh transaction with start pulses in SEND, WAIT and DONE, all ignored.
        exp_q.push_back('{EV_VALID, 24'h5A5A01});
        model_result = 24'h5A5A01;
        fork
            send_cmd(8'h3C, acc);
            begin
                repeat (50) @(negedge clk);
                bus.cmd = 8'hFF; bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
            end
        join
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        send_byte(8'h01, 1'b1); repeat (2) @(negedge clk);
        send_byte(8'h5A, 1'b1); repeat (2) @(negedge clk);
        fork
            send_byte(8'h5A, 1'b1);
            begin
                repeat (VALID_LAT - 1) @(negedge clk);
                bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
            end
        join
        lows = 0;
        v0 = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!bus.ser_tx) lows++;
            if (bus.busy) v0++;
        end
        check("no_second_frame", lows, 0);
        check("busy_stays_low", v0, 0);
        check("result_5a5a01", bus.result, 24'h5A5A01);
        check("scoreboard_final", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
